// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequences calculator arithmetic between keypad decoder and arith unit.
// Latches the pending operator, runs a start/done handshake on equals, strobes the result
// into the operand registers, and traps faulting or hung arith operations in ERROR.
// Optional feature macro: CALC_CHAIN_EN (operator chaining, newop in PENDING acts as equals).
module calc_op_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_newhex,
   input  logic       i_newop,
   input  logic [1:0] i_opcode,
   input  logic       i_eq,
   input  logic       i_arith_done,
   input  logic       i_arith_err,
   output logic       o_arith_start,
   output logic [1:0] o_arith_op,
   output logic       o_ans_load,
   output logic       o_busy,
   output logic       o_err,
   output logic       o_op_valid,
   output logic [1:0] o_pending_op
);

   typedef enum logic [2:0] {
      StIdle,
      StPending,
      StStart,
      StWait,
      StLoad,
      StError
   } state_t;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_pending_op, w_pending_op_nxt;

`ifdef CALC_CHAIN_EN
   logic [1:0] r_next_op, w_next_op_nxt;
   logic       r_chain, w_chain_nxt;
`endif

   // State, timeout counter and operator registers; reset aborts any operation at once.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_pending_op <= 2'b00;
`ifdef CALC_CHAIN_EN
         r_next_op    <= 2'b00;
         r_chain      <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pending_op <= w_pending_op_nxt;
`ifdef CALC_CHAIN_EN
         r_next_op    <= w_next_op_nxt;
         r_chain      <= w_chain_nxt;
`endif
      end
   end

   // Next-state logic; keypad events are only looked at in IDLE, PENDING and ERROR.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_pending_op_nxt = r_pending_op;
`ifdef CALC_CHAIN_EN
      w_next_op_nxt    = r_next_op;
      w_chain_nxt      = r_chain;
`endif
      unique case (r_state)
         StIdle: begin
            if (i_newop) begin
               w_pending_op_nxt = i_opcode;
               w_state_nxt      = StPending;
            end
         end
         StPending: begin
            if (i_eq) begin
               w_state_nxt = StStart;
`ifdef CALC_CHAIN_EN
               // A simultaneous operator becomes the follow-on operation.
               w_chain_nxt = i_newop;
               if (i_newop) w_next_op_nxt = i_opcode;
`endif
            end else if (i_newop) begin
`ifdef CALC_CHAIN_EN
               w_state_nxt   = StStart;
               w_chain_nxt   = 1'b1;
               w_next_op_nxt = i_opcode;
`else
               w_pending_op_nxt = i_opcode;
`endif
            end
         end
         StStart: begin
            w_state_nxt = StWait;
            w_cnt_nxt   = '0;
         end
         StWait: begin
            // Done takes priority over a timeout expiring in the same cycle.
            if (i_arith_done) begin
               w_state_nxt = i_arith_err ? StError : StLoad;
`ifdef CALC_CHAIN_EN
               if (i_arith_err) w_chain_nxt = 1'b0;
`endif
            end else if (r_cnt == CntLast) begin
               w_state_nxt = StError;
`ifdef CALC_CHAIN_EN
               w_chain_nxt = 1'b0;
`endif
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         StLoad: begin
            w_state_nxt = StIdle;
`ifdef CALC_CHAIN_EN
            if (r_chain) begin
               w_pending_op_nxt = r_next_op;
               w_chain_nxt      = 1'b0;
               w_state_nxt      = StPending;
            end
`endif
         end
         StError: begin
            if (i_newop) begin
               w_pending_op_nxt = i_opcode;
               w_state_nxt      = StPending;
            end else if (i_newhex) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Outputs decode registered state only, so reset clears them without a clock edge.
   always_comb begin
      o_arith_start = (r_state == StStart);
      o_ans_load    = (r_state == StLoad);
      o_busy        = (r_state == StStart) || (r_state == StWait) || (r_state == StLoad);
      o_err         = (r_state == StError);
      o_op_valid    = (r_state == StPending);
      o_pending_op  = r_pending_op;
      o_arith_op    = o_busy ? r_pending_op : 2'b00;
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed self-checking bench for calc_op_sequencer (timeout shortened to 8 cycles).
module tb_calc_op_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       newhex, newop, eq, arith_done, arith_err;
   logic [1:0] opcode;
   logic       arith_start, ans_load, busy, err, op_valid;
   logic [1:0] arith_op, pending_op;

   int total = 0;
   int bad   = 0;

   calc_op_sequencer #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (4)
   ) dut (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_newhex     (newhex),
      .i_newop      (newop),
      .i_opcode     (opcode),
      .i_eq         (eq),
      .i_arith_done (arith_done),
      .i_arith_err  (arith_err),
      .o_arith_start(arith_start),
      .o_arith_op   (arith_op),
      .o_ans_load   (ans_load),
      .o_busy       (busy),
      .o_err        (err),
      .o_op_valid   (op_valid),
      .o_pending_op (pending_op)
   );

   always #5 clock = ~clock;

   // {arith_start, arith_op, ans_load, busy, err, op_valid, pending_op}
   function automatic logic [8:0] outs();
      return {arith_start, arith_op, ans_load, busy, err, op_valid, pending_op};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_op(input logic [1:0] code);
      newop = 1'b1; opcode = code;
      tick();
      newop = 1'b0;
   endtask

   task automatic pulse_eq();
      eq = 1'b1;
      tick();
      eq = 1'b0;
   endtask

   task automatic pulse_done(input logic e);
      arith_done = 1'b1; arith_err = e;
      tick();
      arith_done = 1'b0; arith_err = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      newhex = 1'b0; newop = 1'b0; eq = 1'b0; opcode = 2'b00;
      arith_done = 1'b0; arith_err = 1'b0;

      // 1: reset held three cycles, then released; lone eq does nothing
      tick(); tick(); tick();
      check("reset_held", outs(), 9'b0_00_0_0_0_0_00);
      reset = 1'b0;
      tick();
      check("reset_release", outs(), 9'b0_00_0_0_0_0_00);
      pulse_eq();
      check("idle_eq_ignored", outs(), 9'b0_00_0_0_0_0_00);

      // 2: sub, done three cycles after start
      pulse_op(2'b01);
      check("t2_pending", outs(), 9'b0_00_0_0_0_1_01);
      pulse_eq();
      check("t2_start", outs(), 9'b1_01_0_1_0_0_01);
      tick();
      check("t2_wait1", outs(), 9'b0_01_0_1_0_0_01);
      tick();
      check("t2_wait2", outs(), 9'b0_01_0_1_0_0_01);
      pulse_done(1'b0);
      check("t2_load", outs(), 9'b0_01_1_1_0_0_01);
      tick();
      check("t2_idle", outs(), 9'b0_00_0_0_0_0_01);

      // 3: mul, never done -> timeout after 8 WAIT cycles
      pulse_op(2'b10);
      pulse_eq();
      check("t3_start", outs(), 9'b1_10_0_1_0_0_10);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t3_wait%0d", i), outs(), 9'b0_10_0_1_0_0_10);
      end
      tick();
      check("t3_error", outs(), 9'b0_00_0_0_1_0_10);
      newhex = 1'b1;
      tick();
      newhex = 1'b0;
      check("t3_newhex_clear", outs(), 9'b0_00_0_0_0_0_10);

      // 4: add, done with fault -> ERROR, no ans_load
      pulse_op(2'b00);
      pulse_eq();
      tick();
      check("t4_wait", outs(), 9'b0_00_0_1_0_0_00);
      pulse_done(1'b1);
      check("t4_error", outs(), 9'b0_00_0_0_1_0_00);
      tick();
      check("t4_error_hold", outs(), 9'b0_00_0_0_1_0_00);
      pulse_eq();
      check("t4_eq_in_error", outs(), 9'b0_00_0_0_1_0_00);
      pulse_op(2'b01);
      check("t4_newop_clear", outs(), 9'b0_00_0_0_0_1_01);

      // 6b: keypad pulses during WAIT are dropped
      pulse_eq();
      tick();
      pulse_op(2'b11);
      pulse_eq();
      newhex = 1'b1;
      tick();
      newhex = 1'b0;
      check("t6_busy_ignored", outs(), 9'b0_01_0_1_0_0_01);
      pulse_done(1'b0);
      check("t6_load", outs(), 9'b0_01_1_1_0_0_01);
      tick();
      check("t6_idle", outs(), 9'b0_00_0_0_0_0_01);

      // 5: two operators then equals
      pulse_op(2'b00);
      check("t5_pending00", outs(), 9'b0_00_0_0_0_1_00);
      pulse_op(2'b10);
`ifdef CALC_CHAIN_EN
      check("t5_chain_start", outs(), 9'b1_00_0_1_0_0_00);
      pulse_eq();
      check("t5_eq_dropped", outs(), 9'b0_00_0_1_0_0_00);
      pulse_done(1'b0);
      check("t5_load", outs(), 9'b0_00_1_1_0_0_00);
      tick();
      check("t5_chain_pending", outs(), 9'b0_00_0_0_0_1_10);
      pulse_eq();
      check("t5_second_start", outs(), 9'b1_10_0_1_0_0_10);
      tick();
`else
      check("t5_overwrite", outs(), 9'b0_00_0_0_0_1_10);
      pulse_eq();
      check("t5_start", outs(), 9'b1_10_0_1_0_0_10);
      tick();
      check("t5_wait", outs(), 9'b0_10_0_1_0_0_10);
`endif
      pulse_done(1'b0);
      check("t5_final_load", outs(), 9'b0_10_1_1_0_0_10);
      tick();
      check("t5_final_idle", outs(), 9'b0_00_0_0_0_0_10);

      // 6a: asynchronous reset in WAIT, then a late done is ignored
      pulse_op(2'b11);
      pulse_eq();
      tick();
      check("t6_wait_pre_reset", outs(), 9'b0_11_0_1_0_0_11);
      #2 reset = 1'b1;
      #1;
      check("t6_async_reset", outs(), 9'b0_00_0_0_0_0_00);
      arith_done = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("t6_late_done", outs(), 9'b0_00_0_0_0_0_00);
      arith_done = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
